// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner. Drives one row low at a time,
// samples the columns, debounces whole 16-key frames and reports single-key
// press/release events with a held key code.
module keypad_scan #(
  parameter int SCAN_DIV = 50_000,
  parameter int DB_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_rel,
  output logic       key_down,
  output logic       multi_key
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DB_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DB_SCANS);

  // Key FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  // Handshake note: key_valid and key_rel are single-cycle strobes with no
  // back-pressure; key_code is valid from the key_valid cycle until the next
  // key_valid, and key_down is the level view of the same press.

  logic [3:0]    col_s1, col_s2;
  logic [TW-1:0] tick;
  logic [1:0]    row_idx;
  logic [1:0]    row_idx_next;
  logic [15:0]   frame, frame_next, prev_frame, debounced;
  logic [SW-1:0] stable_cnt, stable_inc;
  logic          sample, frame_end, frame_same, load_db;
  logic [1:0]    state;
  logic [4:0]    db_count;
  logic [3:0]    db_index;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) cnt = cnt + {4'd0, v[i]};
    return cnt;
  endfunction

  // Two-flop synchronizer for the asynchronous column lines (idle high)
  always_ff @(posedge clk) begin
    if (reset) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
    end
  end

  assign sample       = (tick == TICK_LAST);
  assign frame_end    = sample && (row_idx == 2'd3);
  assign row_idx_next = row_idx + 2'd1;

  // Tick counter, row counter and registered active-low row strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      tick    <= '0;
      row_idx <= 2'd0;
      row     <= 4'b1110;
    end else if (sample) begin
      tick    <= '0;
      row_idx <= row_idx_next;
      row     <= ~(4'b0001 << row_idx_next);
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // Frame image with the current row's columns merged in (1 = pressed)
  always_comb begin
    frame_next = frame;
    frame_next[{row_idx, 2'b00} +: 4] = ~col_s2;
  end

  assign frame_same = (frame_next == prev_frame);
  assign stable_inc = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
  assign load_db    = frame_end && frame_same && (stable_inc == STABLE_MAX);

  // Frame capture and whole-frame debounce
  always_ff @(posedge clk) begin
    if (reset) begin
      frame      <= '0;
      prev_frame <= '0;
      stable_cnt <= '0;
      debounced  <= '0;
    end else if (sample) begin
      frame <= frame_next;
      if (frame_end) begin
        prev_frame <= frame_next;
        stable_cnt <= frame_same ? stable_inc : '0;
        if (load_db) debounced <= frame_next;
      end
    end
  end

  // Population count and index of the (highest) pressed key in the map
  always_comb begin
    db_count = popcount16(debounced);
    db_index = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (debounced[i]) db_index = 4'(i);
    end
  end

  // Key event FSM; debounced only moves at frame ends, so evaluating every
  // cycle reacts exactly on the cycle after an update
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_rel   <= 1'b0;
      key_down  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      key_rel   <= 1'b0;
      multi_key <= (db_count > 5'd1);
      case (state)
        ST_IDLE: begin
          if (db_count == 5'd1) begin
            key_code  <= db_index;
            key_valid <= 1'b1;
            key_down  <= 1'b1;
            state     <= ST_HELD;
          end else if (db_count > 5'd1) begin
            state <= ST_LOCK;
          end
        end
        ST_HELD: begin
          if (debounced == 16'd0) begin
            key_rel  <= 1'b1;
            key_down <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_LOCK: begin
          if (debounced == 16'd0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
